// File: rtl/if_stage_ctrl.sv
// Fetch-stage front end: owns PC and the IF/ID register, handles load-use stall,
// EX redirects and the imem req/ready handshake. Optional perf counters: `PERF_CNT_EN.
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_if,
    output logic [31:0] o_instr_id,
    output logic [31:0] o_pc4_id,
    output logic        o_valid_id,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;

    logic [31:0] w_tgt;
    logic [31:0] w_pc_plus4;

    assign w_tgt      = {i_redirect_pc[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_req      <= 1'b1;
            r_pc       <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_instr_id <= NOP_INSTR;
            r_pc4_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end else begin
            r_req <= 1'b1;
            case (r_state)
                ST_RUN: begin
                    if (i_redirect) begin
                        r_instr_id <= NOP_INSTR;
                        r_valid_id <= 1'b0;
                        if (i_imem_ready) begin
                            r_pc <= w_tgt;
                        end else begin
                            // request in flight: keep address stable, remember target
                            r_pend_pc <= w_tgt;
                            r_state   <= ST_DRAIN;
                        end
                    end else if (i_stall) begin
                        r_pc <= r_pc;
                    end else if (!i_imem_ready) begin
                        r_instr_id <= NOP_INSTR;
                        r_valid_id <= 1'b0;
                    end else begin
                        r_instr_id <= i_imem_rdata;
                        r_pc4_id   <= w_pc_plus4;
                        r_valid_id <= 1'b1;
                        r_pc       <= w_pc_plus4;
                    end
                end
                ST_DRAIN: begin
                    r_instr_id <= NOP_INSTR;
                    r_valid_id <= 1'b0;
                    if (i_redirect) begin
                        r_pend_pc <= w_tgt;
                    end
                    if (i_imem_ready) begin
                        r_pc    <= i_redirect ? w_tgt : r_pend_pc;
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_pc;
    assign o_pc_if     = r_pc;
    assign o_instr_id  = r_instr_id;
    assign o_pc4_id    = r_pc4_id;
    assign o_valid_id  = r_valid_id;

`ifdef PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // saturating event counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (i_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (i_redirect && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = 32'd0;
    assign o_flush_cnt = 32'd0;
`endif

endmodule
